// File: rtl/ctrl_seq_pkg.sv
// Shared types for the control-vector sequencer: stored vector layout, FSM states, run modes.
package ctrl_seq_pkg;

    localparam int VEC_W  = 24;
    localparam int CTRL_W = 19;

    // Bit 0 is reg_src[0]; chk_en is the MSB (bit 23).
    typedef struct packed {
        logic       chk_en;
        logic [3:0] exp_flags;
        logic [7:0] addr_vga;
        logic       pc_src;
        logic       mem_to_reg;
        logic [1:0] alu_control;
        logic       alu_src;
        logic [1:0] imm_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_src;
    } vec_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRIVE    = 3'd1,
        CHECK    = 3'd2,
        STEPWAIT = 3'd3,
        DONE     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_LOOP   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

endpackage

// File: rtl/ctrl_vec_ram.sv
// Vector store: DEPTH x VEC_W register array, synchronous write, asynchronous read.
module ctrl_vec_ram
    import ctrl_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  vec_t              wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output vec_t              rdata_o
);

    vec_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ctrl_vector_sequencer.sv
// Replays stored control vectors onto the datapath, each held HOLD_CYCLES cycles, and
// compares ALUFlags against the vector's expected flags on the last edge of its window.
module ctrl_vector_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int  DEPTH       = 16,
    parameter int  HOLD_CYCLES = 1,
    parameter int  ERR_W       = 8,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic [ADDR_W:0]   num_vec,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              halt_on_err,
    input  logic [3:0]        ALUFlags,
    output logic [1:0]        RegSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [1:0]        ImmSrc,
    output logic              ALUSrc,
    output logic [1:0]        ALUControl,
    output logic              MemtoReg,
    output logic              PCSrc,
    output logic [7:0]        addressForVga,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vec_idx,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] err_first
);

    localparam int     HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    // With a one-cycle window the first cycle of a vector is already its check cycle.
    localparam state_e ENTER_ST = (HOLD_CYCLES == 1) ? CHECK : DRIVE;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] vec_idx_q, vec_idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_first_q, err_first_d;
    vec_t              drv_q, drv_d, rd_vec;
    logic              busy_d, last, mismatch;
    mode_e             mode_s;

    ctrl_vec_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (wr_en && !busy),
        .waddr_i (wr_addr),
        .wdata_i (vec_t'(wr_data)),
        .raddr_i (idx_d),
        .rdata_o (rd_vec)
    );

    assign mode_s   = mode_e'(mode);
    assign last     = ({1'b0, idx_q} == (num_q - 1'b1));
    assign mismatch = (state_q == CHECK) && drv_q.chk_en && (ALUFlags != drv_q.exp_flags);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vec_idx_q   <= '0;
            hold_q      <= '0;
            num_q       <= '0;
            err_cnt_q   <= '0;
            err_first_q <= '0;
            drv_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_idx_q   <= vec_idx_d;
            hold_q      <= hold_d;
            num_q       <= num_d;
            err_cnt_q   <= err_cnt_d;
            err_first_q <= err_first_d;
            drv_q       <= drv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        num_d       = num_q;
        err_cnt_d   = err_cnt_q;
        err_first_d = err_first_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        num_d       = (num_vec > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vec;
                        idx_d       = '0;
                        hold_d      = '0;
                        err_cnt_d   = '0;
                        err_first_d = '0;
                        state_d     = (num_vec == '0) ? DONE : ENTER_ST;
                    end
                end
                DRIVE: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_W'(HOLD_CYCLES - 2)) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    hold_d = '0;
                    if (mismatch) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        if (err_cnt_q == '0) err_first_d = idx_q;
                    end
                    if (halt_on_err && mismatch) begin
                        state_d = DONE;
                    end else if (mode_s == MODE_STEP) begin
                        state_d = STEPWAIT;
                    end else if (!last) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ENTER_ST;
                    end else if (mode_s == MODE_LOOP) begin
                        idx_d   = '0;
                        state_d = ENTER_ST;
                    end else begin
                        state_d = DONE;
                    end
                end
                STEPWAIT: begin
                    if (step) begin
                        if (last) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            hold_d  = '0;
                            state_d = ENTER_ST;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Write enables fire only in the first cycle of a window and never while parked in STEPWAIT.
    always_comb begin
        drv_d  = '0;
        busy_d = (state_d == DRIVE) || (state_d == CHECK) || (state_d == STEPWAIT);
        if (busy_d) begin
            drv_d = rd_vec;
            if ((state_d == STEPWAIT) || (hold_d != '0)) begin
                drv_d.reg_write = 1'b0;
                drv_d.mem_write = 1'b0;
            end
        end
        vec_idx_d = busy_d ? idx_d : '0;
    end

    assign RegSrc        = drv_q.reg_src;
    assign RegWrite      = drv_q.reg_write;
    assign MemWrite      = drv_q.mem_write;
    assign ImmSrc        = drv_q.imm_src;
    assign ALUSrc        = drv_q.alu_src;
    assign ALUControl    = drv_q.alu_control;
    assign MemtoReg      = drv_q.mem_to_reg;
    assign PCSrc         = drv_q.pc_src;
    assign addressForVga = drv_q.addr_vga;
    assign busy          = (state_q == DRIVE) || (state_q == CHECK) || (state_q == STEPWAIT);
    assign done          = (state_q == DONE);
    assign vec_idx       = vec_idx_q;
    assign err_cnt       = err_cnt_q;
    assign err_first     = err_first_q;

endmodule

// File: tb/tb_ctrl_vector_sequencer.sv
// Two sequencers (HOLD_CYCLES 1 and 3) share stimulus; per-cycle expectations are queued
// as each run is launched and a monitor pops and compares them after every rising edge.
module tb_ctrl_vector_sequencer;

    typedef struct packed {
        logic [18:0] ctrl;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk, reset, wr_en, start, stop, step, halt_on_err;
    logic [3:0]  wr_addr, ALUFlags;
    logic [23:0] wr_data;
    logic [4:0]  num_vec;
    logic [1:0]  mode;

    logic [1:0] a_regsrc, a_immsrc, a_aluc, b_regsrc, b_immsrc, b_aluc;
    logic       a_regwrite, a_memwrite, a_alusrc, a_memtoreg, a_pcsrc, a_busy, a_done;
    logic       b_regwrite, b_memwrite, b_alusrc, b_memtoreg, b_pcsrc, b_busy, b_done;
    logic [7:0] a_addr, b_addr, a_err, b_err;
    logic [3:0] a_idx, b_idx, a_first, b_first;

    obs_t obs_a, obs_b, ea, eb;
    obs_t qa[$], qb[$];
    logic [23:0] shadow [16];
    int checks = 0;
    int errors = 0;

    ctrl_vector_sequencer #(.DEPTH(16), .HOLD_CYCLES(1), .ERR_W(8)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .mode(mode), .start(start), .stop(stop), .step(step),
        .halt_on_err(halt_on_err), .ALUFlags(ALUFlags),
        .RegSrc(a_regsrc), .RegWrite(a_regwrite), .MemWrite(a_memwrite), .ImmSrc(a_immsrc),
        .ALUSrc(a_alusrc), .ALUControl(a_aluc), .MemtoReg(a_memtoreg), .PCSrc(a_pcsrc),
        .addressForVga(a_addr), .busy(a_busy), .done(a_done), .vec_idx(a_idx),
        .err_cnt(a_err), .err_first(a_first)
    );

    ctrl_vector_sequencer #(.DEPTH(16), .HOLD_CYCLES(3), .ERR_W(8)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .mode(mode), .start(start), .stop(stop), .step(step),
        .halt_on_err(halt_on_err), .ALUFlags(ALUFlags),
        .RegSrc(b_regsrc), .RegWrite(b_regwrite), .MemWrite(b_memwrite), .ImmSrc(b_immsrc),
        .ALUSrc(b_alusrc), .ALUControl(b_aluc), .MemtoReg(b_memtoreg), .PCSrc(b_pcsrc),
        .addressForVga(b_addr), .busy(b_busy), .done(b_done), .vec_idx(b_idx),
        .err_cnt(b_err), .err_first(b_first)
    );

    assign obs_a = {a_addr, a_pcsrc, a_memtoreg, a_aluc, a_alusrc, a_immsrc, a_memwrite,
                    a_regwrite, a_regsrc, a_idx, a_busy, a_done};
    assign obs_b = {b_addr, b_pcsrc, b_memtoreg, b_aluc, b_alusrc, b_immsrc, b_memwrite,
                    b_regwrite, b_regsrc, b_idx, b_busy, b_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            checks++;
            if (obs_a !== ea) begin
                errors++;
                $display("FAIL sb_hold1 t=%0t: got ctrl=%h idx=%0d busy=%b done=%b, expected ctrl=%h idx=%0d busy=%b done=%b",
                         $time, obs_a.ctrl, obs_a.idx, obs_a.busy, obs_a.done, ea.ctrl, ea.idx, ea.busy, ea.done);
            end
        end
        if (qb.size() != 0) begin
            eb = qb.pop_front();
            checks++;
            if (obs_b !== eb) begin
                errors++;
                $display("FAIL sb_hold3 t=%0t: got ctrl=%h idx=%0d busy=%b done=%b, expected ctrl=%h idx=%0d busy=%b done=%b",
                         $time, obs_b.ctrl, obs_b.idx, obs_b.busy, obs_b.done, eb.ctrl, eb.idx, eb.busy, eb.done);
            end
        end
    end

    // n window cycles of vector idx; only the first may carry the write enables.
    task automatic exp_vec(input bit b, input int idx, input int n, input bit full_first);
        obs_t e;
        for (int h = 0; h < n; h++) begin
            e.ctrl = shadow[idx][18:0];
            if (h != 0 || !full_first) begin
                e.ctrl[2] = 1'b0;
                e.ctrl[3] = 1'b0;
            end
            e.idx  = idx[3:0];
            e.busy = 1'b1;
            e.done = 1'b0;
            if (b) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    task automatic exp_done(input bit b);
        obs_t e;
        e = '0;
        e.done = 1'b1;
        if (b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic load(input int addr, input logic [23:0] data);
        wr_en = 1'b1; wr_addr = addr[3:0]; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        shadow[addr] = data;
    endtask

    task automatic pulse_start(input int n, input logic [1:0] m, input logic h);
        num_vec = n[4:0]; mode = m; halt_on_err = h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_all();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d/%0d expectations left, required 0", name, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (obs_a !== '0 || a_err !== 8'h0 || a_first !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold1: got obs=%h err=%h first=%h, required all 0", obs_a, a_err, a_first);
        end
        checks++;
        if (obs_b !== '0 || b_err !== 8'h0) begin
            errors++;
            $display("FAIL reset_hold3: got obs=%h err=%h, required all 0", obs_b, b_err);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_two_vectors();
        load(0, 24'h055104);
        load(1, 24'h000018);
        exp_vec(0, 0, 1, 1); exp_vec(0, 1, 1, 1); exp_done(0);
        exp_vec(1, 0, 3, 1); exp_vec(1, 1, 3, 1); exp_done(1);
        pulse_start(2, 2'b00, 1'b0);
        wait_drain("two_vectors");
        stop_all();
    endtask

    task automatic test_mismatch();
        load(2, 24'hC80003);
        load(3, 24'h880040);
        ALUFlags = 4'b0001;
        exp_vec(0, 0, 1, 1); exp_vec(0, 1, 1, 1); exp_vec(0, 2, 1, 1); exp_done(0);
        exp_vec(1, 0, 3, 1); exp_vec(1, 1, 3, 1); exp_vec(1, 2, 3, 1); exp_done(1);
        pulse_start(4, 2'b00, 1'b1);
        wait_drain("halt_on_err");
        checks++;
        if (a_err !== 8'd1 || a_first !== 4'd2 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL halt_err_hold1: got err=%0d first=%0d done=%b, required 1/2/1", a_err, a_first, a_done);
        end
        checks++;
        if (b_err !== 8'd1 || b_first !== 4'd2) begin
            errors++;
            $display("FAIL halt_err_hold3: got err=%0d first=%0d, required 1/2", b_err, b_first);
        end
        stop_all();
        checks++;
        if (a_err !== 8'd1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL err_kept_on_stop: got err=%0d busy=%b done=%b, required 1/0/0", a_err, a_busy, a_done);
        end
        ALUFlags = 4'b1001;
        for (int i = 0; i < 4; i++) exp_vec(0, i, 1, 1);
        exp_done(0);
        for (int i = 0; i < 4; i++) exp_vec(1, i, 3, 1);
        exp_done(1);
        pulse_start(4, 2'b00, 1'b0);
        wait_drain("no_halt");
        checks++;
        if (a_err !== 8'd1 || a_first !== 4'd3) begin
            errors++;
            $display("FAIL restart_err: got err=%0d first=%0d, required 1/3", a_err, a_first);
        end
        stop_all();
    endtask

    task automatic test_loop();
        int seq_a [7] = '{0, 1, 2, 0, 1, 2, 0};
        int seq_b [7] = '{0, 0, 0, 1, 1, 1, 2};
        for (int i = 0; i < 7; i++) begin
            exp_vec(0, seq_a[i], 1, 1);
            exp_vec(1, seq_b[i], 1, (i == 0 || i == 3 || i == 6));
        end
        pulse_start(3, 2'b01, 1'b0);
        wait_drain("loop");
        stop_all();
        checks++;
        if (obs_a !== '0 || obs_b !== '0) begin
            errors++;
            $display("FAIL loop_stop: got %h / %h, required 0 / 0", obs_a, obs_b);
        end
        start = 1'b1; stop = 1'b1; num_vec = 5'd2; mode = 2'b00;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++;
        if (obs_a !== '0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same_cycle: got obs=%h busy=%b, required 0/0", obs_a, a_busy);
        end
    endtask

    task automatic test_step();
        exp_vec(0, 0, 1, 1); exp_vec(0, 0, 3, 0);
        exp_vec(1, 0, 3, 1); exp_vec(1, 0, 1, 0);
        pulse_start(2, 2'b10, 1'b0);
        wait_drain("step_wait0");
        step = 1'b1;
        exp_vec(0, 1, 1, 1); exp_vec(0, 1, 2, 0);
        exp_vec(1, 1, 3, 1);
        @(negedge clk);
        step = 1'b0;
        wait_drain("step_wait1");
        step = 1'b1;
        exp_done(0);
        exp_vec(1, 1, 1, 0);
        @(negedge clk);
        step = 1'b0;
        wait_drain("step_last");
        stop_all();
    endtask

    task automatic test_zero_vectors();
        exp_done(0);
        exp_done(1);
        pulse_start(0, 2'b00, 1'b0);
        wait_drain("num_vec_zero");
        stop_all();
    endtask

    task automatic test_write_while_busy();
        pulse_start(1, 2'b01, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 24'hFFFFFF;
        @(negedge clk);
        wr_en = 1'b0;
        stop_all();
        exp_vec(0, 0, 1, 1); exp_done(0);
        exp_vec(1, 0, 3, 1); exp_done(1);
        pulse_start(1, 2'b00, 1'b0);
        wait_drain("write_busy");
        stop_all();
    endtask

    task automatic test_saturation();
        load(0, 24'h800000);
        ALUFlags = 4'hF;
        pulse_start(1, 2'b01, 1'b0);
        repeat (300) @(negedge clk);
        checks++;
        if (a_err !== 8'hFF || a_first !== 4'd0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL err_saturate: got err=%h first=%0d busy=%b, required ff/0/1", a_err, a_first, a_busy);
        end
        stop_all();
        checks++;
        if (a_err !== 8'hFF || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_after_stop: got err=%h busy=%b, required ff/0", a_err, a_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(1, 2'b01, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_err === 8'h0) begin
            errors++;
            $display("FAIL pre_reset_run: got busy=%b err=%h, required 1/nonzero", a_busy, a_err);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs_a !== '0 || a_err !== 8'h0 || a_first !== 4'h0 || obs_b !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got a=%h err=%h first=%h b=%h, required all 0", obs_a, a_err, a_first, obs_b);
        end
        @(negedge clk);
        reset = 1'b0;
        ALUFlags = 4'h0;
        exp_vec(0, 0, 1, 1); exp_done(0);
        exp_vec(1, 0, 3, 1); exp_done(1);
        pulse_start(1, 2'b00, 1'b0);
        wait_drain("store_survives_reset");
        stop_all();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_vec = '0; mode = '0;
        start = 1'b0; stop = 1'b0; step = 1'b0; halt_on_err = 1'b0; ALUFlags = '0;
        test_reset();
        test_two_vectors();
        test_mismatch();
        test_loop();
        test_step();
        test_zero_vectors();
        test_write_while_busy();
        test_saturation();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
